xsm_capture: RTL
================

Name: xsm_capture

Overview:
- Trigger-qualified sample capture buffer that sits directly downstream of the xsm trigger stage.
- Continuously records the same sample stream the trigger stage compares against a threshold, into a circular RAM.
- On a trigger it freezes a window of pre-trigger and post-trigger samples.
- Streams the frozen window out oldest-first over a valid/ready interface to the XSM readout/host path.

Parameters:
- DATA_WIDTH, 16, sample width; matches the trigger stage THRESHOLD_WIDTH.
- DEPTH, 64, capture window length in samples; must be a power of 2, ≥4.
- ADDR_W, $clog2(DEPTH), RAM address and count width (derived, not overridden).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_WIDTH  sample stream, same signal as the trigger stage input.
- sample_valid  in  1  sample_in is valid this cycle.
- trigger_in  in  1  trigger pulse/level from the trigger stage output.
- trigger_type_in  in  1  0 = level, 1 = edge; sampled with trigger_in.
- arm  in  1  single-cycle request to start a capture.
- abort  in  1  cancels any capture or readout.
- pre_count  in  ADDR_W  pre-trigger samples to keep; latched at arm.
- rd_data  out  DATA_WIDTH  readout sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  marks the final (DEPTH-th) readout sample.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  high from trigger acceptance until return to IDLE.
- trig_type  out  1  trigger_type_in latched at acceptance.
- done  out  1  one-cycle pulse after the rd_last handshake.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. rd_valid, rd_last, busy, triggered, trig_type, done all 0; rd_data 0; pointers and counters 0. RAM contents are don't-care.
- FSM states are IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, READOUT.
- IDLE:
  - arm=1 latches pre_q = pre_count, clears wr_ptr and fill_cnt.
  - Next state is PRE_FILL, or WAIT_TRIG if pre_count=0.
  - arm while not in IDLE is ignored.
- Writes: in PRE_FILL, WAIT_TRIG and POST_FILL, each cycle with sample_valid=1 writes sample_in to RAM[wr_ptr], then wr_ptr += 1 (mod DEPTH).
- PRE_FILL:
  - fill_cnt increments on each write.
  - When the write brings fill_cnt to pre_q, go to WAIT_TRIG the next cycle.
  - trigger_in is ignored in this state.
- WAIT_TRIG:
  - Writing continues circularly.
  - The first cycle with trigger_in=1 accepts the trigger: trig_ptr = wr_ptr, trig_type = trigger_type_in, triggered = 1, post_cnt = 0, and the state becomes POST_FILL.
  - If sample_valid=1 in the accept cycle, that sample is post-trigger sample #0 and counts toward post_cnt.
- POST_FILL:
  - post_cnt increments per write.
  - After post_cnt reaches DEPTH - pre_q (a trigger-cycle write counts), writes stop and the state becomes READOUT.
  - Further trigger_in is ignored.
- READOUT:
  - Read address starts at (trig_ptr - pre_q) mod DEPTH and increments mod DEPTH.
  - Exactly DEPTH samples are emitted, oldest first; rd_last is on the DEPTH-th.
  - RAM read latency is 1 cycle; rd_valid first asserts no later than 2 cycles after entering READOUT.
  - rd_data and rd_last are held stable while rd_valid=1 and rd_ready=0.
  - The rd_valid=1 & rd_ready=1 handshake advances to the next sample.
  - A back-to-back ready stream gives 1 sample/cycle throughput after the first.
  - After the rd_last handshake: state IDLE, rd_valid=0, done=1 for one cycle, triggered=0.
- sample_valid is ignored in READOUT and IDLE, so the buffer stays frozen during readout.
- abort=1 in any state: next cycle is IDLE with all outputs at reset values except done=0. abort has priority over arm, trigger_in and handshakes in the same cycle.
- Arithmetic: all pointers are ADDR_W bits and wrap naturally. DEPTH - pre_q is computed in ADDR_W+1 bits. pre_q ≤ DEPTH-1, so post-trigger length ≥ 1.
- Capture window rule: the readout window equals the pre_q samples immediately before trig_ptr, followed by DEPTH - pre_q samples starting at trig_ptr.

Decomposition:
- Shared package xsm_pkg holds the capture FSM state enum (xsm_cap_state_e) and a common sample-width localparam shared with the trigger stage.
- One sub-module, xsm_capture_ram: simple dual-port RAM of DEPTH×DATA_WIDTH, one write port, synchronous read with 1-cycle latency, no reset on the array.

Test Plan (DEPTH=8, DATA_WIDTH=16):
- Reset, then arm with pre_count=3. Samples 1..20 valid every cycle, trigger_in pulses in the cycle sample 10 is written; rd_ready=1. Expected: readout 7,8,9,10,11,12,13,14, rd_last on 14, done pulses once.
- pre_count=0, trigger in the first WAIT_TRIG cycle with samples 100..107. Expected: readout 100..107, trig_type matches trigger_type_in=1.
- trigger_in held high throughout PRE_FILL with pre_count=5. Expected: no acceptance until the 5th write. Window = 5 pre + 3 post samples, triggered rises only in WAIT_TRIG.
- Wrap-around: pre_count=2, trigger after 13 writes (wr_ptr=5). Expected: read start address 3, data correct across the 7→0 wrap.
- rd_ready toggled 1,0,0,1 during readout. Expected: rd_data/rd_last stable while stalled, no sample lost or duplicated, 8 total handshakes.
- abort asserted in POST_FILL, then in READOUT after 3 handshakes. Expected: IDLE next cycle, rd_valid=0, busy=0, no done pulse. A fresh arm then captures normally.

Source files
------------

// File: rtl/xsm_pkg.sv
// Shared definitions for the xsm trigger/capture path.
package xsm_pkg;

    localparam int XSM_SAMPLE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST_FILL = 3'd3,
        ST_READOUT   = 3'd4
    } xsm_cap_state_e;

endpackage

// File: rtl/xsm_capture_ram.sv
// Capture sample store: one write port, registered read port, no reset on the array.
module xsm_capture_ram #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 64,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Read register only updates on i_rd_en, so it holds the last sample during a stall.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/xsm_capture.sv
// Trigger-qualified capture buffer: records samples circularly, freezes a
// pre/post-trigger window and streams it out oldest-first over valid/ready.
//
//   state        | meaning
//   ST_IDLE      | waiting for arm
//   ST_PRE_FILL  | writing the first pre_q samples, trigger ignored
//   ST_WAIT_TRIG | writing circularly, waiting for trigger_in
//   ST_POST_FILL | writing DEPTH - pre_q post-trigger samples
//   ST_READOUT   | streaming the frozen window out
module xsm_capture
    import xsm_pkg::*;
#(
    parameter  int DATA_WIDTH = XSM_SAMPLE_W,
    parameter  int DEPTH      = 64,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  trigger_in,
    input  logic                  trigger_type_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     pre_count,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  triggered,
    output logic                  trig_type,
    output logic                  done
);

    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_W    = (ADDR_W+1)'(1);

    xsm_cap_state_e r_state;
    xsm_cap_state_e w_next_state;

    logic [ADDR_W-1:0]     r_pre_q;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_fill_cnt;
    logic [ADDR_W:0]       r_post_cnt;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W:0]       r_rd_issued;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic                  r_triggered;
    logic                  r_trig_type;
    logic                  r_done;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_rd_hs;
    logic                  w_last_hs;
    logic [ADDR_W:0]       w_post_len;
    logic [ADDR_W-1:0]     w_fill_next;
    logic [ADDR_W:0]       w_post_next;
    logic [DATA_WIDTH-1:0] w_ram_q;

    assign w_post_len  = DEPTH_W - {1'b0, r_pre_q};
    assign w_fill_next = r_fill_cnt + 1'b1;
    assign w_post_next = r_post_cnt + 1'b1;
    assign w_accept    = (r_state == ST_WAIT_TRIG) && trigger_in && !abort;
    assign w_rd_hs     = r_rd_valid && rd_ready;
    assign w_last_hs   = w_rd_hs && r_rd_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:
                    if (arm) w_next_state = (pre_count == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
                ST_PRE_FILL:
                    if (w_wr_en && (w_fill_next == r_pre_q)) w_next_state = ST_WAIT_TRIG;
                // A one-sample post window is complete in the accept cycle itself.
                ST_WAIT_TRIG:
                    if (trigger_in)
                        w_next_state = (sample_valid && (w_post_len == ONE_W)) ? ST_READOUT
                                                                               : ST_POST_FILL;
                ST_POST_FILL:
                    if (w_wr_en && (w_post_next == w_post_len)) w_next_state = ST_READOUT;
                ST_READOUT:
                    if (w_last_hs) w_next_state = ST_IDLE;
                default:
                    w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        if (!abort) begin
            w_wr_en = sample_valid && ((r_state == ST_PRE_FILL) ||
                                       (r_state == ST_WAIT_TRIG) ||
                                       (r_state == ST_POST_FILL));
            w_rd_en = (r_state == ST_READOUT) && (r_rd_issued != DEPTH_W) &&
                      (!r_rd_valid || rd_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_pre_q     <= '0;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_post_cnt  <= '0;
            r_rd_addr   <= '0;
            r_rd_issued <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_triggered <= 1'b0;
            r_trig_type <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last_hs;

            if ((r_state == ST_IDLE) && arm) begin
                r_pre_q    <= pre_count;
                r_wr_ptr   <= '0;
                r_fill_cnt <= '0;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_wr_en && (r_state == ST_PRE_FILL)) r_fill_cnt <= w_fill_next;

            // Window start is fixed at acceptance: pre_q slots behind the trigger write.
            if (w_accept) begin
                r_trig_type <= trigger_type_in;
                r_triggered <= 1'b1;
                r_post_cnt  <= {{ADDR_W{1'b0}}, sample_valid};
                r_rd_addr   <= r_wr_ptr - r_pre_q;
                r_rd_issued <= '0;
            end else if (w_wr_en && (r_state == ST_POST_FILL)) begin
                r_post_cnt <= w_post_next;
            end

            if (w_rd_en) begin
                r_rd_addr   <= r_rd_addr + 1'b1;
                r_rd_issued <= r_rd_issued + 1'b1;
                r_rd_valid  <= 1'b1;
                r_rd_last   <= (r_rd_issued == DEPTH_M1);
            end else if (w_rd_hs) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end

            if (w_last_hs) r_triggered <= 1'b0;
        end
    end

    xsm_capture_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (sample_in),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign rd_data   = r_rd_valid ? w_ram_q : '0;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign busy      = w_busy;
    assign triggered = r_triggered;
    assign trig_type = r_trig_type;
    assign done      = r_done;

endmodule
